// File: rtl/caravel_openframe.sv
// Openframe chip top: pin-configured 16-bit periodic/one-shot timer on the gpio pads.
// Clock enters on gpio[38], reset on resetb; all other functional I/O is on gpio.
module caravel_openframe #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NUM_IO = 44
) (
  inout  logic [NUM_IO-1:0] gpio,
  input  logic              resetb,
  inout  logic              vddio,
  inout  logic              vssio,
  inout  logic              vdda,
  inout  logic              vssa,
  inout  logic              vccd,
  inout  logic              vssd,
  inout  logic              vdda1,
  inout  logic              vdda2,
  inout  logic              vssa1,
  inout  logic              vssa2,
  inout  logic              vccd1,
  inout  logic              vccd2,
  inout  logic              vssd1,
  inout  logic              vssd2
);

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] per_q;
  logic             en_q;
  logic             clr_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             tog_q, tog_d;
  logic             done_q, done_d;
  logic             run;

  assign clk   = gpio[38];
  assign rst_n = resetb;
  assign run   = en_q & ~done_q;

  // Input pads and the clock pad are never driven; output pads always are.
  assign gpio[18:0]  = 'z;
  assign gpio[37:19] = {run, cnt_q, tog_q, tick_q};
  assign gpio[38]    = 'z;
  assign gpio[43:39] = 'z;

  logic unused_pads;
  assign unused_pads = &{gpio[43:39], gpio[37:19], vddio, vssio, vdda, vssa, vccd, vssd,
                         vdda1, vdda2, vssa1, vssa2, vccd1, vccd2, vssd1, vssd2};

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    tog_d  = tog_q;
    done_d = done_q;
    if (clr_q) begin
      cnt_d  = '0;
      tog_d  = 1'b0;
      done_d = 1'b0;
    end else if (run) begin
      // >= rather than == so a period shrunk below the count wraps immediately.
      if (cnt_q >= per_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        tog_d  = ~tog_q;
        done_d = mode_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q  <= '0;
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      tog_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      per_q  <= gpio[CNT_W-1:0];
      en_q   <= gpio[16];
      clr_q  <= gpio[17];
      mode_q <= gpio[18];
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      tog_q  <= tog_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_caravel_openframe.sv
// Randomized and directed bench for caravel_openframe against a cycle-level reference model.
module tb_caravel_openframe;

  wire  [43:0] gpio;
  logic        resetb;
  logic        clk;
  logic [15:0] pad_per;
  logic        pad_en, pad_clr, pad_mode;
  wire         pwr = 1'b1;
  wire         gnd = 1'b0;

  assign gpio[15:0]  = pad_per;
  assign gpio[16]    = pad_en;
  assign gpio[17]    = pad_clr;
  assign gpio[18]    = pad_mode;
  assign gpio[38]    = clk;
  assign gpio[43:39] = 5'b10101;

  caravel_openframe #(.CNT_W(16), .NUM_IO(44)) dut (
    .gpio(gpio), .resetb(resetb),
    .vddio(pwr), .vssio(gnd), .vdda(pwr), .vssa(gnd), .vccd(pwr), .vssd(gnd),
    .vdda1(pwr), .vdda2(pwr), .vssa1(gnd), .vssa2(gnd), .vccd1(pwr), .vccd2(pwr),
    .vssd1(gnd), .vssd2(gnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state: staged pad values plus the timer state.
  int unsigned m_per, m_cnt;
  bit m_en, m_clr, m_mode, m_tick, m_tog, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] exp_outs();
    logic [15:0] c;
    c = m_cnt[15:0];
    return {m_en & ~m_done, c, m_tog, m_tick};
  endfunction

  task automatic model_reset();
    m_per = 0; m_cnt = 0; m_en = 0; m_clr = 0; m_mode = 0;
    m_tick = 0; m_tog = 0; m_done = 0;
  endtask

  task automatic model_edge();
    if (m_clr) begin
      m_cnt = 0; m_tick = 0; m_tog = 0; m_done = 0;
    end else if (m_en && !m_done) begin
      if (m_cnt >= m_per) begin
        m_cnt = 0; m_tick = 1; m_tog = !m_tog; m_done = m_mode;
      end else begin
        m_cnt = (m_cnt + 1) % 65536; m_tick = 0;
      end
    end else begin
      m_tick = 0;
    end
    m_per = pad_per; m_en = pad_en; m_clr = pad_clr; m_mode = pad_mode;
  endtask

  task automatic set_pads(input int unsigned per, input bit en, input bit clr, input bit mode);
    pad_per = per[15:0]; pad_en = en; pad_clr = clr; pad_mode = mode;
  endtask

  task automatic cycles(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      if (resetb) model_edge(); else model_reset();
      #2;
      check(tag, 32'(gpio[37:19]), 32'(exp_outs()));
    end
  endtask

  initial begin
    model_reset();
    set_pads(16'h5a5a, 1'b1, 1'b0, 1'b1);
    resetb = 1'b0;
    cycles(3, "reset_outs");
    check("reset_in_pads", 32'(gpio[18:0]), 32'h5_5a5a);
    check("reset_hi_pads", 32'(gpio[43:39]), 32'h15);
    check("reset_zero", 32'(gpio[37:19]), 32'h0);

    @(negedge clk);
    set_pads(4, 1'b0, 1'b1, 1'b0);
    resetb = 1'b1;
    cycles(2, "clr_init");
    set_pads(4, 1'b1, 1'b0, 1'b0);
    cycles(16, "periodic");

    set_pads(3, 1'b0, 1'b1, 1'b1);
    cycles(2, "os_clr");
    set_pads(3, 1'b1, 1'b0, 1'b1);
    cycles(14, "oneshot");
    check("oneshot_done", 32'(gpio[37:19]), 32'h0_0002);
    set_pads(3, 1'b1, 1'b1, 1'b1);
    cycles(1, "os_rearm");
    set_pads(3, 1'b1, 1'b0, 1'b1);
    cycles(3, "os_rearm");
    check("oneshot_run", 32'(gpio[37]), 32'h1);

    set_pads(20, 1'b0, 1'b1, 1'b0);
    cycles(2, "pause_clr");
    set_pads(20, 1'b1, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 40 && m_cnt != 6; k++) cycles(1, "pause_run");
    set_pads(20, 1'b0, 1'b0, 1'b0);
    cycles(5, "pause_hold");
    check("pause_cnt7", 32'(gpio[36:21]), 32'd7);
    set_pads(20, 1'b1, 1'b0, 1'b0);
    cycles(3, "pause_resume");
    check("resume_cnt9", 32'(gpio[36:21]), 32'd9);

    set_pads(0, 1'b1, 1'b0, 1'b0);
    cycles(10, "per0");
    check("per0_tick", 32'(gpio[19]), 32'h1);

    set_pads(100, 1'b1, 1'b1, 1'b0);
    cycles(2, "shrink_clr");
    set_pads(100, 1'b1, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 200 && m_cnt != 49; k++) cycles(1, "shrink_run");
    set_pads(2, 1'b1, 1'b0, 1'b0);
    cycles(1, "shrink_stage");
    check("shrink_cnt50", 32'(gpio[36:21]), 32'd50);
    cycles(1, "shrink_wrap");
    check("shrink_tick", 32'(gpio[36:19]), 32'h1 | (32'(m_tog) << 1));

    set_pads(7, 1'b1, 1'b1, 1'b0);
    cycles(3, "clr_en");
    check("clr_en_zero", 32'(gpio[36:19]), 32'h0);

    for (int unsigned i = 0; i < 1500; i++) begin
      set_pads(($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 12),
               $urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0);
      cycles(1, "random");
    end

    set_pads(30, 1'b1, 1'b0, 1'b0);
    cycles(12, "async_pre");
    #3;
    resetb = 1'b0;
    #1;
    model_reset();
    check("async_reset", 32'(gpio[37:19]), 32'h0);
    @(negedge clk);
    resetb = 1'b1;
    cycles(8, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
